// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants and helpers for the pipelined add/subtract unit.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest result the saturation helper can describe.
  localparam int SAT_MAX_W = 64;

  // Signed extreme for a given width: most-negative when neg=1, most-positive otherwise.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1) begin
        v[i] = ~neg;
      end else if (i == width - 1) begin
        v[i] = neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: purely combinational W-bit slice of the carry chain. Also exposes
// the carry into its top bit so the most significant slice can derive signed overflow.
module addsub_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  if (W == 1) begin : g_one
    assign msb_cin = cin;
  end else begin : g_multi
    logic [W-1:0] low;
    assign low         = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
    assign msb_cin     = low[W-1];
    assign sum[W-2:0]  = low[W-2:0];
  end

  assign sum[W-1] = a[W-1] ^ b[W-1] ^ msb_cin;
  assign cout     = (a[W-1] & b[W-1]) | (msb_cin & (a[W-1] ^ b[W-1]));

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/subtract with the carry chain cut into STAGES segments,
// one register per segment, valid/ready on both sides with full back-pressure.
// Define ADDSUB_SATURATE_EN to add the 'sat' input that clamps overflowing
// results to the signed extreme.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG_W  = WIDTH / STAGES;
  localparam int PIPE_N = (STAGES > 1) ? STAGES - 1 : 1;

  logic             advance;
  logic [WIDTH-1:0] bp_in;
  logic             cin0;

  // Inter-stage registers: entry k holds what stage k hands to stage k+1.
  logic             v_q  [PIPE_N];
  logic             c_q  [PIPE_N];
  logic [WIDTH-1:0] a_q  [PIPE_N];
  logic [WIDTH-1:0] bp_q [PIPE_N];
  logic [WIDTH-1:0] s_q  [PIPE_N];
`ifdef ADDSUB_SATURATE_EN
  logic             sat_q [PIPE_N];
`endif

  // The whole pipeline moves together whenever the output slot is free or draining.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction becomes a + ~b + ~cin so one adder serves both operations.
  assign bp_in = (op == OP_SUB) ? ~b : b;
  assign cin0  = (op == OP_ADD) ? cin : ~cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_bp;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
`ifdef ADDSUB_SATURATE_EN
    logic             src_sat;
`endif
    logic [SEG_W-1:0] seg_s;
    logic             seg_co;
    logic             seg_mc;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_head
      assign src_v  = in_valid;
      assign src_a  = a;
      assign src_bp = bp_in;
      assign src_s  = '0;
      assign src_c  = cin0;
`ifdef ADDSUB_SATURATE_EN
      assign src_sat = sat;
`endif
    end else begin : g_body
      assign src_v  = v_q[k-1];
      assign src_a  = a_q[k-1];
      assign src_bp = bp_q[k-1];
      assign src_s  = s_q[k-1];
      assign src_c  = c_q[k-1];
`ifdef ADDSUB_SATURATE_EN
      assign src_sat = sat_q[k-1];
`endif
    end

    addsub_seg #(.W(SEG_W)) u_seg (
      .a       (src_a[k*SEG_W +: SEG_W]),
      .b       (src_bp[k*SEG_W +: SEG_W]),
      .cin     (src_c),
      .sum     (seg_s),
      .cout    (seg_co),
      .msb_cin (seg_mc)
    );

    // Merge this stage's finished segment into the partial result travelling with it.
    always_comb begin
      s_next = src_s;
      s_next[k*SEG_W +: SEG_W] = seg_s;
    end

    if (k < STAGES - 1) begin : g_mid
      // Hand the carry, skewed operands and deskewed partial sum to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q[k] <= 1'b0;
        end else if (advance) begin
          v_q[k]  <= src_v;
          c_q[k]  <= seg_co;
          a_q[k]  <= src_a;
          bp_q[k] <= src_bp;
          s_q[k]  <= s_next;
`ifdef ADDSUB_SATURATE_EN
          sat_q[k] <= src_sat;
`endif
        end
      end
    end else begin : g_tail
      logic             ovf_next;
      logic [WIDTH-1:0] sum_next;

      assign ovf_next = seg_mc ^ seg_co;

`ifdef ADDSUB_SATURATE_EN
      logic [SAT_MAX_W-1:0] sat_val;
      assign sat_val  = sat_value(WIDTH, src_a[WIDTH-1]);
      assign sum_next = (src_sat && ovf_next) ? sat_val[WIDTH-1:0] : s_next;
`else
      assign sum_next = s_next;
`endif

      // Output register: the last segment completes here and the full word is presented.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (advance) begin
          out_valid <= src_v;
          sum       <= sum_next;
          cout      <= seg_co;
          ovf       <= ovf_next;
        end
      end
    end
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised add/subtract unit whose carry chain is split into STAGES equal segments, one register stage per segment. It has a valid/ready handshake on input and output, with full back-pressure. It replaces the single-stage registered adder in datapaths that need higher clock rates or a streaming interface. It also reports signed overflow alongside carry-out.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of carry segments = pipeline depth, 1..WIDTH.
SEG_W, WIDTH/STAGES, segment width (localparam, not overridable).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  input transaction present.
in_ready  out  1  block can accept input this cycle.
a  in  WIDTH  operand A (unsigned/two's complement, same bits).
b  in  WIDTH  operand B.
cin  in  1  carry-in (add) / borrow-in (sub).
op  in  1  0 = add, 1 = subtract.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result this cycle.
sum  out  WIDTH  result.
cout  out  1  carry-out; for subtract, 1 = no borrow.
ovf  out  1  signed overflow of the full-width operation.

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0 the following cycle. in_ready is combinational and may be 1 during reset, but transfers in that cycle are discarded.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: computed as a + ~b + ~cin, i.e. sum = a - b - cin (mod 2^WIDTH); cout = 1 iff a >= b + cin (unsigned).
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' = b for add and ~b for sub.
- Pipeline:
  - Stage k (0..STAGES-1) adds segment k of A and B' with the carry registered from stage k-1. Stage 0 uses cin for add and ~cin for sub.
  - Upper operand segments are skewed through delay registers; completed lower result segments are deskewed so all WIDTH bits emerge together.
- Latency: exactly STAGES cycles from an accepted input to out_valid, when not stalled. STAGES=1 gives a single registered adder.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - An input transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
  - When advance=0 the whole pipeline holds: every register keeps its value and outputs stay stable.
  - Bubbles (valid=0) propagate like data; there is no compaction.
- Throughput: one result per cycle with out_ready held high. No transaction is lost, duplicated or reordered.
- Simultaneous events: a result leaving and a new input entering in the same cycle is legal and does not stall.
- Reset mid-operation flushes all in-flight transactions; none emerge after reset.
- Inputs a, b, cin, op are don't-care when in_valid=0. Outputs sum/cout/ovf are don't-care when out_valid=0, but must hold stable while out_valid=1 && out_ready=0.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- Defined: adds input port sat (1 bit), captured with the transaction. When sat=1 and ovf=1, sum clamps to the signed extreme: 0x7FF..F if A_msb=0, 0x800..0 if A_msb=1. ovf still reports 1; cout is unaffected.
- Undefined: port absent; sum always wraps.

Decomposition:
- Package addsub_pkg: OP_ADD=1'b0, OP_SUB=1'b1 constants; function computing the signed saturation value for a given width.
- One sub-module, addsub_seg: a SEG_W-bit combinational segment adder (a, b, cin -> sum, cout, plus the MSB carry-in needed for ovf on the top segment). Instantiated STAGES times via a generate loop; all registers live in the top module.

Test Plan:
(All with WIDTH=16, STAGES=4.)
- Reset: hold rst 2 cycles, then release -> out_valid=0, sum=0x0000, cout=0, ovf=0; first result appears only after an accepted input.
- Segment carry crossing: add 0x00FF + 0x0001, cin=0 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
- Add wrap and overflow:
  - 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0010 - 0x0001, cin=1 -> sum=0x000E, cout=1.
- Back-pressure: stream 8 random transactions, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results correct and in order against a scoreboard.
- Reset flush: assert rst for 1 cycle with 3 transactions in flight -> no out_valid for those transactions; the next input's result emerges 4 cycles after acceptance.
